ulv_deser_rx: RTL and testbench
===============================

// Module: ulv_deser_rx
// PURPOSE
//  Serial-in/parallel-out frame receiver: the receiving end of the ulv shift-register serial link.
//  Collects N qualified serial bits into a word, frames each word on a start-of-frame strobe,
//  and presents the word on a single-entry valid/ready output. Sits between the serial pin logic and word-level consumers.
// PARAMETERS
//  N          8  word width in bits (N >= 2)
//  MSB_FIRST  1  1: first bit received lands in q[N-1]; 0: first bit lands in q[0]
// PORTS
//  clk         input   1  system clock, rising edge
//  reset       input   1  asynchronous, active-high reset
//  sin         input   1  serial data bit
//  sin_valid   input   1  sin is sampled only when high
//  sof         input   1  start of frame; qualified by sin_valid; marks the first bit of a word
//  q           output  N  received word
//  q_valid     output  1  q holds an unconsumed word
//  q_ready     input   1  consumer accepts q when q_valid & q_ready
//  overrun     output  1  sticky: a completed word was dropped
//  parity_err  output  1  parity status of the word in q (tied 0 without PARITY_CHECK_EN)
// BEHAVIOUR
//  - Reset (async, high): state=IDLE, bit count=0, shift reg=0, q=0, q_valid=0, overrun=0, parity_err=0.
//    Reset mid-frame discards the partial word.
//  - Bit accept = sin_valid high on a rising clk edge; cycles with sin_valid low hold all state (gaps allowed).
//  - Shift: MSB_FIRST=1 -> sr <= {sr[N-2:0], sin}; MSB_FIRST=0 -> sr <= {sin, sr[N-1:1]}.
//  - FSM:
//    IDLE : accept with sof=1 -> sr loaded with the bit, count=1, go to SHIFT. Accept with sof=0 -> ignored.
//    SHIFT: accept with sof=1 -> restart: the bit becomes bit 1 of a new word, count=1, partial word discarded.
//           Accept with sof=0 -> shift, count+1. Accepting bit N completes the word -> IDLE (or PAR).
//    PAR  : (macro only) next accept = parity bit; sof ignored in PAR; completes the word -> IDLE.
//  - Completion: q and q_valid update on the same edge that accepts the last bit. The assembled word is written
//    directly to q; latency 0 cycles after the edge, visible in the following cycle.
//  - Output handshake: q_valid clears on an edge where q_valid & q_ready, unless a word completes on that same edge.
//    On completion with q_valid=0, or with q_valid=1 & q_ready=1: q <= new word, q_valid=1.
//    On completion with q_valid=1 & q_ready=0: new word dropped, q unchanged, overrun <= 1.
//  - overrun clears only on reset. Count width = $clog2(N+1); count never exceeds N.
// CONFIGURATION
//  ULV_DESER_PARITY_CHECK_EN defined:
//    - After bit N, the FSM enters PAR. The next accepted bit is an even-parity bit.
//    - parity_err <= ^{word, pbit} is loaded together with q; it is meaningful while q_valid=1.
//    - Overrun drops word and parity alike.
//  Undefined: no PAR state; the word completes on bit N; parity_err is constant 0.
// STRUCTURE
//  - Package ulv_deser_pkg holds:
//    - state_e enum {IDLE, SHIFT, PAR}
//    - function cnt_w(N) = $clog2(N+1)
//  - Sub-module ulv_out_buf holds the single-entry valid/ready register: q, q_valid, parity_err, overrun.
//    Inputs: load, data, perr, q_ready.
// TESTING (N=8, T=20ns, reset high for the first T/2)
//  1. Reset for T/2, no stimulus -> q=8'h00, q_valid=0, overrun=0, parity_err=0.
//  2. MSB_FIRST=1, q_ready=1, sof on the first bit, stream 1,0,1,0,0,1,0,1 -> q=8'hA5, q_valid high for 1 cycle.
//  3. As case 2 with sin_valid low for 3 cycles after bit 4 -> q=8'hA5; no q_valid before bit 8.
//  4. Three bits, then a new sof frame of 8'h3C -> only q=8'h3C is delivered; exactly one q_valid pulse.
//  5. q_ready=0, frames 8'h05 then 8'h06 -> q stays 8'h05, overrun=1; then q_ready=1 for 1 cycle -> q_valid=0, overrun remains 1.
//  6. Reset pulse after 4 bits, then frame 8'h0A -> q=8'h0A.
//     With macro, 8'hA5 + pbit 0 -> parity_err=0; 8'hA5 + pbit 1 -> parity_err=1.

Source files
------------

// File: rtl/ulv_deser_pkg.sv
// Shared types and helpers for the ulv serial receiver.
package ulv_deser_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_e;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ulv_out_buf.sv
// Single-entry valid/ready word register. A load lands in the same cycle; a load
// against a held, unaccepted word is dropped and sets the sticky overrun flag.
module ulv_out_buf #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [N-1:0] data,
  input  logic         perr,
  input  logic         q_ready,
  output logic [N-1:0] q,
  output logic         q_valid,
  output logic         parity_err,
  output logic         overrun
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q          <= '0;
      q_valid    <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else if (load) begin
      if (!q_valid || q_ready) begin
        q          <= data;
        q_valid    <= 1'b1;
        parity_err <= perr;
      end else begin
        overrun    <= 1'b1;
      end
    end else if (q_valid && q_ready) begin
      q_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ulv_deser_rx.sv
// Serial-to-parallel frame receiver; word is visible the cycle after its last bit, held until consumed.
// ULV_DESER_PARITY_CHECK_EN adds a trailing even-parity bit per word.
module ulv_deser_rx
  import ulv_deser_pkg::*;
#(
  parameter int N         = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sin,
  input  logic         sin_valid,
  input  logic         sof,
  output logic [N-1:0] q,
  output logic         q_valid,
  input  logic         q_ready,
  output logic         overrun,
  output logic         parity_err
);

  localparam int CW = cnt_w(N);

  state_e        state;
  logic [CW-1:0] cnt;
  logic [N-1:0]  sr;
  logic [N-1:0]  shifted;
  logic [N-1:0]  first;
  logic [N-1:0]  word;
  logic          load;
  logic          perr;

  assign shifted = MSB_FIRST ? {sr[N-2:0], sin} : {sin, sr[N-1:1]};
  assign first   = MSB_FIRST ? {{(N-1){1'b0}}, sin} : {sin, {(N-1){1'b0}}};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      sr    <= '0;
    end else if (sin_valid) begin
      case (state)
        IDLE: begin
          if (sof) begin
            sr    <= first;
            cnt   <= CW'(1);
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (sof) begin
            sr  <= first;
            cnt <= CW'(1);
          end else begin
            sr <= shifted;
            if (cnt == CW'(N - 1)) begin
`ifdef ULV_DESER_PARITY_CHECK_EN
              state <= PAR;
              cnt   <= CW'(N);
`else
              state <= IDLE;
              cnt   <= '0;
`endif
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        PAR: begin
          state <= IDLE;
          cnt   <= '0;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Completion is decoded combinationally so the word reaches the buffer on the accepting edge.
  always_comb begin
    load = 1'b0;
    perr = 1'b0;
    word = shifted;
    if (sin_valid) begin
`ifdef ULV_DESER_PARITY_CHECK_EN
      if (state == PAR) begin
        load = 1'b1;
        word = sr;
        perr = ^{sr, sin};
      end
`else
      if (state == SHIFT && !sof && cnt == CW'(N - 1)) begin
        load = 1'b1;
      end
`endif
    end
  end

  ulv_out_buf #(.N(N)) u_out_buf (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .data       (word),
    .perr       (perr),
    .q_ready    (q_ready),
    .q          (q),
    .q_valid    (q_valid),
    .parity_err (parity_err),
    .overrun    (overrun)
  );

endmodule

// File: tb/tb_ulv_deser_rx.sv
// Randomized and directed bench for ulv_deser_rx against a bit-list reference model.
module tb_ulv_deser_rx;

  localparam int N   = 8;
  localparam bit MSB = 1'b1;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         sin = 1'b0;
  logic         sin_valid = 1'b0;
  logic         sof = 1'b0;
  logic         q_ready = 1'b0;
  logic [N-1:0] q;
  logic         q_valid;
  logic         overrun;
  logic         parity_err;

  ulv_deser_rx #(.N(N), .MSB_FIRST(MSB)) dut (
    .clk        (clk),
    .reset      (reset),
    .sin        (sin),
    .sin_valid  (sin_valid),
    .sof        (sof),
    .q          (q),
    .q_valid    (q_valid),
    .q_ready    (q_ready),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  always #10 clk = ~clk;

  int    n_checks = 0;
  int    n_pass   = 0;
  int    pulses   = 0;
  string phase    = "reset";

  // Reference model: list of bits collected since the last sof, plus the output register.
  bit           bq[$];
  bit           coll, in_par;
  logic [N-1:0] pw;
  logic [N-1:0] eq;
  bit           ev, eo, ep;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s.%s: got %0h expected %0h", phase, tag, obs, exp);
  endtask

  function automatic logic [N-1:0] assemble(input bit b[$]);
    logic [N-1:0] w = '0;
    for (int i = 0; i < N; i++) begin
      if (MSB) w = (w << 1) | N'(b[i]);
      else     w = w | (N'(b[i]) << i);
    end
    return w;
  endfunction

  task automatic model_reset();
    bq.delete();
    coll = 0; in_par = 0; pw = '0;
    eq = '0; ev = 0; eo = 0; ep = 0;
  endtask

  task automatic model_edge(input bit s, input bit v, input bit f, input bit r);
    bit           done = 0;
    logic [N-1:0] w = '0;
    bit           p = 0;
    if (v) begin
      if (in_par) begin
        done = 1; w = pw; p = (^pw) ^ s; in_par = 0;
      end else if (f) begin
        bq.delete(); bq.push_back(s); coll = 1;
      end else if (coll) begin
        bq.push_back(s);
        if (bq.size() == N) begin
          coll = 0;
`ifdef ULV_DESER_PARITY_CHECK_EN
          in_par = 1; pw = assemble(bq);
`else
          done = 1; w = assemble(bq);
`endif
        end
      end
    end
    if (done) begin
      if (!ev || r) begin eq = w; ev = 1; ep = p; end
      else eo = 1;
    end else if (ev && r) begin
      ev = 0;
    end
  endtask

  task automatic cycle(input bit s, input bit v, input bit f, input bit r);
    sin = s; sin_valid = v; sof = f; q_ready = r;
    @(posedge clk);
    model_edge(s, v, f, r);
    #1;
    chk("q", q, eq);
    chk("q_valid", q_valid, ev);
    chk("overrun", overrun, eo);
    chk("parity_err", parity_err, ep);
    if (q_valid) pulses++;
  endtask

  task automatic send(input logic [N-1:0] w, input bit r, input int gap_after, input bit pb);
    bit b;
    for (int i = 0; i < N; i++) begin
      b = MSB ? w[N-1-i] : w[i];
      cycle(b, 1'b1, i == 0, r);
      if (i + 1 == gap_after) repeat (3) cycle(1'b1, 1'b0, 1'b1, r);
    end
`ifdef ULV_DESER_PARITY_CHECK_EN
    cycle(pb, 1'b1, 1'b1, r);
`endif
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    model_reset();
    chk("rst_q", q, 0);
    chk("rst_q_valid", q_valid, 0);
  endtask

  initial begin
    model_reset();
    #5;
    chk("q", q, 0);
    chk("q_valid", q_valid, 0);
    chk("overrun", overrun, 0);
    chk("parity_err", parity_err, 0);
    #5 reset = 1'b0;
    #3;

    phase = "basic";
    send(8'hA5, 1'b1, -1, 1'b0);
    chk("word", q, 8'hA5);
    chk("valid", q_valid, 1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("valid_drop", q_valid, 0);

    phase = "gap";
    send(8'hA5, 1'b1, 4, 1'b0);
    chk("word", q, 8'hA5);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);

    phase = "restart";
    pulses = 0;
    cycle(1'b1, 1'b1, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    send(8'h3C, 1'b1, -1, 1'b0);
    chk("word", q, 8'h3C);
    repeat (2) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("pulses", pulses, 1);

    phase = "overrun";
    send(8'h05, 1'b0, -1, 1'b0);
    send(8'h06, 1'b0, -1, 1'b0);
    chk("word", q, 8'h05);
    chk("sticky", overrun, 1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("valid", q_valid, 0);
    chk("sticky_hold", overrun, 1);

    phase = "midreset";
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, i == 0, 1'b1);
    pulse_reset();
    chk("overrun", overrun, 0);
    send(8'h0A, 1'b1, -1, 1'b0);
    chk("word", q, 8'h0A);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);

`ifdef ULV_DESER_PARITY_CHECK_EN
    phase = "parity";
    send(8'hA5, 1'b1, -1, 1'b0);
    chk("even", parity_err, 0);
    send(8'hA5, 1'b1, -1, 1'b1);
    chk("odd", parity_err, 1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
`endif

    phase = "rand_frames";
    for (int k = 0; k < 40; k++) begin
      send(N'($urandom), $urandom_range(3) != 0, int'($urandom_range(N)), 1'($urandom));
      if ($urandom_range(4) == 0) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    end

    phase = "rand_bits";
    for (int k = 0; k < 600; k++) begin
      cycle(1'($urandom), $urandom_range(3) != 0, $urandom_range(9) == 0, $urandom_range(2) != 0);
      if (k == 300) pulse_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
